// File: rtl/seq_playback_ctrl.sv
// -----------------------------------------------------------------------------
// seq_playback_ctrl
//
// Plays the stimulus sequence of a NeuroSync round on the LEDs before the
// player responds. On start the block walks an external sequence memory
// (combinational read) from address 0 to len-1. Each entry is shown for an
// on-time, then the LEDs go dark for a gap. A one-cycle done pulse tells the
// round controller that playback has finished.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous, active-low reset
//   start      in   playback request, sampled only in IDLE
//   abort      in   synchronous return to IDLE from any state, no done pulse
//   nivel      in   0 = normal speed, 1 = fast (half on-time); latched at start
//   len        in   number of entries to play (0..15); latched at start
//   rom_data   in   memory word at rom_addr, valid in the same cycle
//   rom_addr   out  current sequence address
//   leds       out  registered LED drive
//   busy       out  high while in FETCH / SHOW / GAP
//   done       out  one-cycle pulse at the end of playback
//   db_estado  out  current state encoding for a debug display
//
// Every output is a flop: next-state and next-output values are computed
// together in one combinational block and registered in one sequential block.
// -----------------------------------------------------------------------------
module seq_playback_ctrl #(
   parameter int ON_CYCLES  = 1000,  // on-time at nivel=0, even and >= 2
   parameter int OFF_CYCLES = 500,   // dark gap after each entry, >= 1
   parameter int TW         = 16     // timer width
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       nivel,
   input  logic [3:0] len,
   input  logic [3:0] rom_data,
   output logic [3:0] rom_addr,
   output logic [3:0] leds,
   output logic       busy,
   output logic       done,
   output logic [2:0] db_estado
);

   // State encoding doubles as the debug display code.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SHOW  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Terminal counts; the timer counts 0 .. N-1 in SHOW and in GAP.
   localparam logic [TW-1:0] ON_FULL_LAST = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] ON_HALF_LAST = TW'(ON_CYCLES / 2 - 1);
   localparam logic [TW-1:0] OFF_LAST     = TW'(OFF_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   logic [2:0]    state,    state_n;
   logic [TW-1:0] timer,    timer_n;
   logic [3:0]    addr_q,   addr_n;
   logic [3:0]    leds_q,   leds_n;
   logic          busy_q,   busy_n;
   logic          done_q,   done_n;
   logic [3:0]    len_q,    len_n;
   logic          nivel_q,  nivel_n;

   // Derived from the latched values only, so len/nivel changes on the inputs
   // during playback cannot disturb the running sequence.
   logic [TW-1:0] on_last;
   logic [3:0]    last_addr;
   logic          show_end;
   logic          gap_end;

   assign on_last   = nivel_q ? ON_HALF_LAST : ON_FULL_LAST;
   assign last_addr = len_q - 4'd1;
   assign show_end  = (timer == on_last);
   assign gap_end   = (timer == OFF_LAST);

   // ---------------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      timer_n = timer;
      addr_n  = addr_q;
      leds_n  = leds_q;
      len_n   = len_q;
      nivel_n = nivel_q;

      case (state)
         S_IDLE: begin
            leds_n  = 4'd0;
            addr_n  = 4'd0;
            timer_n = '0;
            if (start) begin
               if (len != 4'd0) begin
                  len_n   = len;
                  nivel_n = nivel;
                  state_n = S_FETCH;
               end else begin
                  // Empty sequence: report completion straight away.
                  state_n = S_DONE;
               end
            end
         end

         S_FETCH: begin
            // Memory read is combinational, so the word is already valid.
            leds_n  = rom_data;
            timer_n = '0;
            state_n = S_SHOW;
         end

         S_SHOW: begin
            if (show_end) begin
               leds_n  = 4'd0;
               timer_n = '0;
               state_n = S_GAP;
            end else begin
               timer_n = timer + 1'b1;
            end
         end

         S_GAP: begin
            leds_n = 4'd0;
            if (gap_end) begin
               timer_n = '0;
               if (addr_q == last_addr) begin
                  state_n = S_DONE;
               end else begin
                  // Address stops at len-1, so it never wraps.
                  addr_n  = addr_q + 4'd1;
                  state_n = S_FETCH;
               end
            end else begin
               timer_n = timer + 1'b1;
            end
         end

         S_DONE: begin
            leds_n  = 4'd0;
            addr_n  = 4'd0;
            timer_n = '0;
            state_n = S_IDLE;
         end

         default: begin
            // Unreachable encodings recover to a clean idle.
            leds_n  = 4'd0;
            addr_n  = 4'd0;
            timer_n = '0;
            state_n = S_IDLE;
         end
      endcase

      // Abort wins over every transition above, including a pending DONE.
      if (abort) begin
         state_n = S_IDLE;
         leds_n  = 4'd0;
         addr_n  = 4'd0;
         timer_n = '0;
      end

      // busy/done are registered copies of the state being entered, so they
      // line up with db_estado without a combinational decode on the output.
      busy_n = (state_n == S_FETCH) || (state_n == S_SHOW) || (state_n == S_GAP);
      done_n = (state_n == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         timer   <= '0;
         addr_q  <= 4'd0;
         leds_q  <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         len_q   <= 4'd0;
         nivel_q <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         addr_q  <= addr_n;
         leds_q  <= leds_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         len_q   <= len_n;
         nivel_q <= nivel_n;
      end
   end

   assign rom_addr  = addr_q;
   assign leds      = leds_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign db_estado = state;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for seq_playback_ctrl. A reference model tracks, per cycle, how far
// playback has progressed since start and derives every expected output from
// that position with plain arithmetic (entry = t / entry_len, offset = t %
// entry_len). Directed steps cover the listed scenarios; a randomized section
// follows with random ROM contents, lengths, speeds, stray start pulses,
// input changes mid-run and occasional aborts.
// -----------------------------------------------------------------------------
module tb_seq_playback_ctrl;

   localparam int ON  = 4;
   localparam int OFF = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic       nivel;
   logic [3:0] len;
   logic [3:0] rom_data;
   logic [3:0] rom_addr;
   logic [3:0] leds;
   logic       busy;
   logic       done;
   logic [2:0] db_estado;

   logic [3:0] rom [16];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model: playing flag, cycles since start, latched len/on-time
   bit m_active;
   int m_t;
   int m_len;
   int m_on;

   // per-run statistics
   int done_cyc;
   int n_done;
   int n_busy;
   int n_leds;

   always #5 clock = ~clock;

   assign rom_data = rom[rom_addr];

   seq_playback_ctrl #(
      .ON_CYCLES (ON),
      .OFF_CYCLES(OFF),
      .TW        (8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .nivel    (nivel),
      .len      (len),
      .rom_data (rom_data),
      .rom_addr (rom_addr),
      .leds     (leds),
      .busy     (busy),
      .done     (done),
      .db_estado(db_estado)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Model update for one rising edge, using the inputs the DUT just sampled.
   task automatic m_edge();
      int e;
      if (abort) begin
         m_active = 0;
      end else if (m_active) begin
         e = 1 + m_on + OFF;
         if (m_t == 1 + m_len * e) m_active = 0;   // leaving DONE
         else m_t++;
      end else if (start) begin
         m_active = 1;
         m_t      = 1;
         m_len    = int'(len);
         m_on     = nivel ? ON / 2 : ON;
      end
   endtask

   task automatic check_all();
      int e, i, o;
      logic [2:0] es;
      logic [3:0] el, ea;
      logic eb, ed;
      bit ck_addr;
      es = 3'd0; el = 4'd0; ea = 4'd0; eb = 1'b0; ed = 1'b0; ck_addr = 1;
      if (m_active) begin
         e = 1 + m_on + OFF;
         if (m_t == 1 + m_len * e) begin
            es = 3'd4; ed = 1'b1; ck_addr = 0;
         end else begin
            i  = (m_t - 1) / e;
            o  = (m_t - 1) % e;
            ea = 4'(i);
            eb = 1'b1;
            if (o == 0) es = 3'd1;
            else if (o <= m_on) begin es = 3'd2; el = rom[i]; end
            else es = 3'd3;
         end
      end
      chk("state", 32'(db_estado), 32'(es));
      chk("leds",  32'(leds),      32'(el));
      chk("busy",  32'(busy),      32'(eb));
      chk("done",  32'(done),      32'(ed));
      if (ck_addr) chk("rom_addr", 32'(rom_addr), 32'(ea));
   endtask

   task automatic tick();
      @(posedge clock);
      m_edge();
      cyc++;
      #1;
      check_all();
   endtask

   // Run n cycles after start has been raised; collects statistics.
   task automatic run(input int n, input bit tog_nivel, input bit noisy);
      cyc = 0; done_cyc = -1; n_done = 0; n_busy = 0; n_leds = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (done === 1'b1) begin n_done++; done_cyc = cyc; end
         if (busy === 1'b1) n_busy++;
         if (leds !== 4'd0) n_leds++;
         start = 1'b0;
         if (tog_nivel) nivel = ~nivel;
         if (noisy) begin
            start = (cyc < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cyc == 5) len = 4'd5;
         end
      end
   endtask

   initial begin
      int guard;
      reset = 1'b0; start = 1'b0; abort = 1'b0; nivel = 1'b0; len = 4'd0;
      for (int i = 0; i < 16; i++) rom[i] = 4'd0;
      m_active = 0; m_t = 0; m_len = 0; m_on = ON;

      // reset values
      #2;
      chk("rst_state", 32'(db_estado), 0);
      chk("rst_leds",  32'(leds), 0);
      chk("rst_addr",  32'(rom_addr), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      #10 reset = 1'b1;
      tick(); tick();

      // basic three-entry playback
      rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100;
      len = 4'd3; nivel = 1'b0; start = 1'b1;
      run(25, 0, 0);
      chk("t1_done_cyc", 32'(done_cyc), 22);
      chk("t1_done_cnt", 32'(n_done), 1);
      chk("t1_busy_cnt", 32'(n_busy), 21);

      // fast speed, nivel toggled during the run
      nivel = 1'b1; start = 1'b1;
      run(20, 1, 0);
      chk("t2_done_cyc", 32'(done_cyc), 16);
      chk("t2_done_cnt", 32'(n_done), 1);

      // empty sequence
      nivel = 1'b0; len = 4'd0; start = 1'b1;
      run(5, 0, 0);
      chk("t3_done_cyc", 32'(done_cyc), 1);
      chk("t3_busy_cnt", 32'(n_busy), 0);
      chk("t3_leds_cnt", 32'(n_leds), 0);

      // abort during SHOW of entry 1, then replay from entry 0
      len = 4'd3; start = 1'b1; cyc = 0;
      tick(); start = 1'b0;
      while (cyc < 10) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_state", 32'(db_estado), 0);
      chk("t4_leds",  32'(leds), 0);
      chk("t4_addr",  32'(rom_addr), 0);
      chk("t4_done",  32'(done), 0);
      tick(); tick();
      start = 1'b1;
      run(25, 0, 0);
      chk("t4_done_cyc", 32'(done_cyc), 22);
      chk("t4_done_cnt", 32'(n_done), 1);

      // start pulses while busy, len changed mid-run
      len = 4'd3; start = 1'b1;
      run(25, 0, 1);
      len = 4'd3;
      chk("t5_done_cyc", 32'(done_cyc), 22);
      chk("t5_done_cnt", 32'(n_done), 1);

      // asynchronous reset in the GAP of entry 1
      start = 1'b1; cyc = 0;
      tick(); start = 1'b0;
      while (cyc < 13) tick();
      #3 reset = 1'b0;
      #1;
      m_active = 0;
      chk("t6_state", 32'(db_estado), 0);
      chk("t6_leds",  32'(leds), 0);
      chk("t6_addr",  32'(rom_addr), 0);
      chk("t6_busy",  32'(busy), 0);
      chk("t6_done",  32'(done), 0);
      #2 reset = 1'b1;
      tick(); tick(); tick();
      chk("t6_idle", 32'(db_estado), 0);

      // randomized runs
      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
         len   = 4'($urandom_range(0, 15));
         nivel = 1'($urandom_range(0, 1));
         start = 1'b1;
         tick();
         start = 1'b0;
         guard = 0;
         while (m_active && guard < 200) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) nivel = ~nivel;
            abort = ($urandom_range(0, 79) == 0);
            tick();
            guard++;
         end
         start = 1'b0; abort = 1'b0;
         checks++;
         if (guard >= 200) begin
            errors++;
            $display("FAIL rand_timeout: run %0d did not finish, required finish within 200 cycles", r);
         end
         tick(); tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_playback_ctrl.md
Name: seq_playback_ctrl

Overview:
Sequencer that plays the stimulus sequence of a NeuroSync round on the LEDs before the player responds. On start it walks a sequence memory from address 0 to len-1. Each entry is shown on leds for an on-time, then leds go dark for a gap. It signals completion so the round controller can hand over to the response phase. The block owns the sequence memory address bus and the LED drive during playback; the memory is external with combinational read.

Parameters:
ON_CYCLES, 1000, LED on-time per entry at nivel=0 (must be even and >=2)
OFF_CYCLES, 500, dark gap after each entry (>=1)
TW, 16, timer width; must hold max(ON_CYCLES,OFF_CYCLES)-1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces all state to reset values
start  in  1  request playback; sampled in IDLE only
abort  in  1  synchronous; returns to IDLE from any state, no done pulse
nivel  in  1  0=normal speed, 1=fast (on-time = ON_CYCLES/2); latched at start
len    in  4  number of entries to play (0..15); latched at start
rom_data  in  4  memory word at rom_addr, valid same cycle
rom_addr  out  4  current sequence address
leds  out  4  LED drive, registered
busy  out  1  high in FETCH/SHOW/GAP
done  out  1  one-cycle pulse at end of playback
db_estado  out  3  state encoding for debug display

Behaviour:
- States (db_estado): IDLE=0, FETCH=1, SHOW=2, GAP=3, DONE=4. All outputs registered.
- Reset (reset=0, async): state IDLE, rom_addr=0, leds=0, busy=0, done=0, timer=0, latched len/nivel=0.
- IDLE: leds=0, rom_addr=0. If start=1 and len!=0: latch len and nivel, go FETCH. If start=1 and len=0: go DONE. start in any other state is ignored.
- FETCH (1 cycle): leds<=rom_data at rom_addr, timer<=0, go SHOW.
- SHOW: leds held and timer increments. When timer==on_time-1: leds<=0, timer<=0, go GAP. on_time = latched nivel ? ON_CYCLES/2 : ON_CYCLES.
- GAP: leds=0 and timer increments. When timer==OFF_CYCLES-1: if rom_addr==len_latched-1, go DONE; else rom_addr<=rom_addr+1 and go FETCH.
- DONE (1 cycle): done=1, busy=0, rom_addr<=0, then go IDLE.
- Timing: start sampled at edge k. leds show entry 0 from edge k+2. Each entry occupies 1+on_time+OFF_CYCLES cycles. done is high in cycle k+1+len*(1+on_time+OFF_CYCLES).
- An entry of rom_data=0 is still played, with the full timing and leds=0.
- Changing len/nivel during playback has no effect.
- abort=1 takes priority over every transition: next state IDLE, leds=0, rom_addr=0, timer=0, done stays 0.
- reset asserted mid-playback clears everything immediately. After reset is released, a fresh start is required.
- rom_addr never exceeds len_latched-1, so there is no wrap. len=15 plays addresses 0..14.

Test Plan:
- ON=4, OFF=2, len=3, ROM{0:0001,1:0010,2:0100}, start at cycle 0 -> leds=0001 for cycles 2-5, 0 for 6-7, 0010 for 9-12, 0100 for 16-19; done=1 only at cycle 22; busy high cycles 1-21.
- Same setup with nivel=1 -> each entry on for 2 cycles; done at cycle 16. Toggling nivel mid-run does not change the timing.
- len=0, start -> DONE next cycle, done pulse at cycle 1, leds never nonzero, busy never high.
- abort asserted during SHOW of entry 1 -> next cycle IDLE, leds=0, rom_addr=0, no done. A new start replays from entry 0.
- start pulses while busy, and len changed to 5 mid-run -> sequence still plays exactly 3 entries, a single done pulse.
- reset=0 pulsed asynchronously mid-GAP (between clock edges) -> outputs go to reset values immediately. After release, IDLE with db_estado=0.
